alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU-control/ALU pair.
// One operation in flight; illegal opcodes are sequenced but answered with an error.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_aluop,
    input  logic [3:0]       req0_funct,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_aluop,
    input  logic [3:0]       req1_funct,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       alu_aluop,
    output logic [3:0]       alu_funct,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             last_grant_q, last_grant_d;
    logic [1:0]       alu_aluop_q, alu_aluop_d;
    logic [3:0]       alu_funct_q, alu_funct_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic gnt_any;
    logic gnt_id;
    logic op_ok;

    // Opcode legality as understood by the downstream ALU-control decoder.
    function automatic logic op_legal(input logic [1:0] op, input logic [3:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            2'b00: ok = 1'b1;
            2'b01: ok = (fn[2:0] == 3'b000) || (fn[2:0] == 3'b001) ||
                        (fn[2:0] == 3'b101);
            2'b10: ok = (fn == 4'b0000) || (fn == 4'b1000) ||
                        (fn == 4'b0111) || (fn == 4'b0110);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign op_ok = op_legal(alu_aluop_q, alu_funct_q);

    // Round-robin pick; only offered in IDLE and never while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if ((state_q == IDLE) && reset) begin
            case ({req1_valid, req0_valid})
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    gnt_id  = ~last_grant_q;
                end
                default: begin
                    gnt_any = 1'b0;
                    gnt_id  = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any && gnt_id;

    // Next state: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (gnt_any) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: load operands on grant, capture ALU output in EXEC.
    always_comb begin
        last_grant_d = last_grant_q;
        alu_aluop_d  = alu_aluop_q;
        alu_funct_d  = alu_funct_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        if (gnt_any) begin
            last_grant_d = gnt_id;
            rsp_id_d     = gnt_id;
            if (gnt_id) begin
                alu_aluop_d = req1_aluop;
                alu_funct_d = req1_funct;
                alu_a_d     = req1_a;
                alu_b_d     = req1_b;
            end else begin
                alu_aluop_d = req0_aluop;
                alu_funct_d = req0_funct;
                alu_a_d     = req0_a;
                alu_b_d     = req0_b;
            end
        end
        if (state_q == EXEC) begin
            rsp_result_d = op_ok ? alu_result : '0;
            rsp_zero_d   = op_ok && alu_zero;
            rsp_err_d    = !op_ok;
        end
    end

    // Datapath registers; last grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            alu_aluop_q  <= '0;
            alu_funct_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            alu_aluop_q  <= alu_aluop_d;
            alu_funct_q  <= alu_funct_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_aluop  = alu_aluop_q;
    assign alu_funct  = alu_funct_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model.
// A behavioural ALU stands in for the shared ALU-control/ALU pair.
module tb_alu_arbiter;

    localparam int W = 64;

    typedef struct {
        logic [1:0]   aluop;
        logic [3:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_aluop, req1_aluop;
    logic [3:0]   req0_funct, req1_funct;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   alu_aluop;
    logic [3:0]   alu_funct;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [W-1:0] rsp_result;

    int vectors = 0;
    int miscompares = 0;
    int last_g = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_aluop(req0_aluop), .req0_funct(req0_funct),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_aluop(req1_aluop), .req1_funct(req1_funct),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_aluop(alu_aluop), .alu_funct(alu_funct),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Stand-in ALU; unsupported encodings return all-ones with zero set.
    always_comb begin
        alu_result = '1;
        case (alu_aluop)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: begin
                case (alu_funct)
                    4'b0000: alu_result = alu_a + alu_b;
                    4'b1000: alu_result = alu_a - alu_b;
                    4'b0111: alu_result = alu_a & alu_b;
                    4'b0110: alu_result = alu_a | alu_b;
                    default: alu_result = '1;
                endcase
            end
            default: alu_result = '1;
        endcase
        alu_zero = (alu_result == '0) || (alu_result == '1);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: expected response of one operation from the request alone.
    function automatic void model(input op_t o, output logic [W-1:0] r,
                                  output logic z, output logic e);
        bit ok;
        ok = 0;
        r = '0;
        if (o.aluop == 2'b00) begin
            ok = 1;
            r = o.a + o.b;
        end else if (o.aluop == 2'b01) begin
            ok = (o.funct[2:0] inside {3'b000, 3'b001, 3'b101});
            r = o.a - o.b;
        end else if (o.aluop == 2'b10) begin
            ok = 1;
            if (o.funct == 4'b0000) r = o.a + o.b;
            else if (o.funct == 4'b1000) r = o.a - o.b;
            else if (o.funct == 4'b0111) r = o.a & o.b;
            else if (o.funct == 4'b0110) r = o.a | o.b;
            else ok = 0;
        end
        if (!ok) r = '0;
        z = ok && (r == '0);
        e = !ok;
    endfunction

    function automatic int pick(input logic v0, input logic v1);
        if (v0 && v1) return (last_g == 1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_id"}, rsp_id, 0);
        chk({tag, " rsp_result"}, rsp_result, 0);
        chk({tag, " rsp_zero"}, rsp_zero, 0);
        chk({tag, " rsp_err"}, rsp_err, 0);
        chk({tag, " alu_aluop"}, alu_aluop, 0);
        chk({tag, " alu_funct"}, alu_funct, 0);
        chk({tag, " alu_a"}, alu_a, 0);
        chk({tag, " alu_b"}, alu_b, 0);
        chk({tag, " req0_ready"}, req0_ready, 0);
        chk({tag, " req1_ready"}, req1_ready, 0);
    endtask

    // One IDLE cycle offer; if granted, follow through EXEC and RESP.
    task automatic transact(input logic v0, input logic v1, input op_t o0,
                            input op_t o1, input int stall);
        int w;
        op_t g;
        logic [W-1:0] er;
        logic ez, ee;
        @(negedge clk);
        req0_valid = v0; req0_aluop = o0.aluop; req0_funct = o0.funct;
        req0_a = o0.a; req0_b = o0.b;
        req1_valid = v1; req1_aluop = o1.aluop; req1_funct = o1.funct;
        req1_a = o1.a; req1_b = o1.b;
        rsp_ready = (stall == 0);
        #1;
        w = pick(v0, v1);
        chk("idle req0_ready", req0_ready, v0 && (w == 0));
        chk("idle req1_ready", req1_ready, v1 && (w == 1));
        chk("idle rsp_valid", rsp_valid, 0);
        if (w < 0) return;
        last_g = w;
        g = (w == 1) ? o1 : o0;
        model(g, er, ez, ee);
        @(negedge clk); #1;
        chk("exec alu_aluop", alu_aluop, g.aluop);
        chk("exec alu_funct", alu_funct, g.funct);
        chk("exec alu_a", alu_a, g.a);
        chk("exec alu_b", alu_b, g.b);
        chk("exec rsp_valid", rsp_valid, 0);
        chk("exec readies", {req1_ready, req0_ready}, 0);
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            if (i == stall) rsp_ready = 1'b1;
            #1;
            chk("resp rsp_valid", rsp_valid, 1);
            chk("resp rsp_id", rsp_id, w);
            chk("resp rsp_result", rsp_result, er);
            chk("resp rsp_zero", rsp_zero, ez);
            chk("resp rsp_err", rsp_err, ee);
            chk("resp readies", {req1_ready, req0_ready}, 0);
        end
    endtask

    function automatic op_t mk(input logic [1:0] op, input logic [3:0] fn,
                               input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        o.aluop = op; o.funct = fn; o.a = a; o.b = b;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        logic [3:0] pool [4];
        pool[0] = 4'b0000; pool[1] = 4'b1000;
        pool[2] = 4'b0111; pool[3] = 4'b0110;
        o.aluop = 2'($urandom_range(0, 3));
        o.funct = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)]
                                              : 4'($urandom_range(0, 15));
        o.a = {$urandom, $urandom};
        o.b = ($urandom_range(0, 3) == 0) ? o.a : {$urandom, $urandom};
        return o;
    endfunction

    initial begin
        op_t z, p;
        z = mk(2'b00, 4'b0000, 0, 0);
        reset = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_aluop = 0; req0_funct = 0; req0_a = 0; req0_b = 0;
        req1_aluop = 0; req1_funct = 0; req1_a = 0; req1_b = 0;
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single R-type add from requester 0.
        transact(1, 0, mk(2'b10, 4'b0000, 5, 7), z, 0);
        // Illegal aluop from requester 1.
        transact(0, 1, z, mk(2'b11, 4'b0000, 64'h55, 64'h22), 0);
        // Both valid for four ops: alternating ids, subtract to zero.
        p = mk(2'b10, 4'b1000, 3, 3);
        for (int i = 0; i < 4; i++) transact(1, 1, p, p, 0);
        // Branch legal then illegal funct.
        transact(1, 0, mk(2'b01, 4'b0101, 9, 9), z, 0);
        transact(1, 0, mk(2'b01, 4'b0010, 9, 9), z, 0);
        // Response stalled five cycles; requester 0 stays valid throughout.
        p = mk(2'b00, 4'b0011, 64'h100, 64'h23);
        transact(1, 0, p, z, 5);
        transact(1, 0, p, z, 0);
        // A tie here would go to requester 1; reset during EXEC must undo that.
        @(negedge clk);
        req0_valid = 1; req1_valid = 0;
        req0_aluop = 2'b00; req0_funct = 4'b0001; req0_a = 11; req0_b = 4;
        #1;
        chk("pre-reset req0_ready", req0_ready, 1);
        @(negedge clk); #1;
        chk("pre-reset exec alu_a", alu_a, 11);
        reset = 1'b0;
        #1;
        chk_reset_vals("async reset");
        @(negedge clk);
        req0_valid = 0;
        reset = 1'b1;
        last_g = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post-reset rsp_valid", rsp_valid, 0);
        end
        transact(1, 1, mk(2'b10, 4'b0111, 64'hF0F0, 64'hFF00), z, 0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            logic v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            transact(v0, v1, rnd_op(), rnd_op(), $urandom_range(0, 2));
        end

        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
